// File: rtl/md_ctrl_pkg.sv
// Shared encodings and the E-stage control bundle for the MIPS decode/control slice.
package md_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00;
    localparam logic [4:0] RT_BGEZ = 5'h01;

    // mem_sel: bits [1:0] select the access size, bit 2 marks an unsigned load
    localparam logic [2:0] MEM_W  = 3'b000;
    localparam logic [2:0] MEM_B  = 3'b001;
    localparam logic [2:0] MEM_H  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b101;
    localparam logic [2:0] MEM_HU = 3'b110;

    typedef enum logic [3:0] {
        ALU_ADDU = 4'd0, ALU_SUBU = 4'd1, ALU_OR  = 4'd2, ALU_LUI  = 4'd3,
        ALU_SLL  = 4'd4, ALU_XOR  = 4'd5, ALU_AND = 4'd6, ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8, ALU_SRL  = 4'd9, ALU_SRA = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC8 = 2'b10, WD_HILO = 2'b11
    } wd_sel_t;

    typedef enum logic [1:0] {
        RD_RD = 2'b00, RD_RT = 2'b01, RD_RA = 2'b10
    } reg_dst_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE  = 3'd2, BR_BGEZ = 3'd3,
        BR_BGTZ = 3'd4, BR_BLEZ = 3'd5, BR_BLTZ = 3'd6
    } branch_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0, JMP_J = 2'd1, JMP_R = 2'd2
    } jump_t;

    typedef enum logic [2:0] {
        MD_NONE = 3'd0, MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV   = 3'd3,
        MD_DIVU = 3'd4, MD_MFHI = 3'd5, MD_MFLO  = 3'd6, MD_MTHILO = 3'd7
    } md_op_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       sign_ext;
        reg_dst_t   reg_dst;
        wd_sel_t    wd_sel;
        logic [2:0] mem_sel;
        branch_t    branch;
        jump_t      jump;
        md_op_t     md_op;
        logic       hilo_sel;
    } ctrl_bundle_t;

    function automatic ctrl_bundle_t load_ctrl(input logic [2:0] sel);
        ctrl_bundle_t c;
        c           = '0;
        c.alu_op    = ALU_ADDU;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.sign_ext  = 1'b1;
        c.reg_dst   = RD_RT;
        c.wd_sel    = WD_MEM;
        c.mem_sel   = sel;
        return c;
    endfunction

    function automatic ctrl_bundle_t store_ctrl(input logic [2:0] sel);
        ctrl_bundle_t c;
        c           = '0;
        c.alu_op    = ALU_ADDU;
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.sign_ext  = 1'b1;
        c.mem_sel   = sel;
        return c;
    endfunction

    function automatic ctrl_bundle_t imm_alu_ctrl(input alu_op_t op, input logic sext);
        ctrl_bundle_t c;
        c           = '0;
        c.alu_op    = op;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.sign_ext  = sext;
        c.reg_dst   = RD_RT;
        return c;
    endfunction

    function automatic ctrl_bundle_t branch_ctrl(input branch_t br);
        ctrl_bundle_t c;
        c          = '0;
        c.sign_ext = 1'b1;
        c.branch   = br;
        return c;
    endfunction

endpackage

// File: rtl/md_decode_stage_insn_decoder.sv
// Purely combinational instruction decoder: D-stage word to E-stage control bundle.
module insn_decoder
    import md_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic         illegal,
    output logic         uses_md,
    output logic         md_start
);

    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] rt;

    assign opc = instr[31:26];
    assign fn  = instr[5:0];
    assign rt  = instr[20:16];

    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        uses_md  = 1'b0;
        md_start = 1'b0;
        case (opc)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADDU: begin ctrl.alu_op = ALU_ADDU; ctrl.reg_write = 1'b1; end
                    FN_SUBU: begin ctrl.alu_op = ALU_SUBU; ctrl.reg_write = 1'b1; end
                    FN_AND:  begin ctrl.alu_op = ALU_AND;  ctrl.reg_write = 1'b1; end
                    FN_OR:   begin ctrl.alu_op = ALU_OR;   ctrl.reg_write = 1'b1; end
                    FN_XOR:  begin ctrl.alu_op = ALU_XOR;  ctrl.reg_write = 1'b1; end
                    FN_SLT:  begin ctrl.alu_op = ALU_SLT;  ctrl.reg_write = 1'b1; end
                    FN_SLTU: begin ctrl.alu_op = ALU_SLTU; ctrl.reg_write = 1'b1; end
                    FN_SRL:  begin ctrl.alu_op = ALU_SRL;  ctrl.reg_write = 1'b1; end
                    FN_SRA:  begin ctrl.alu_op = ALU_SRA;  ctrl.reg_write = 1'b1; end
                    // The all-zero word is the canonical nop: keep it free of any write
                    FN_SLL:  begin ctrl.alu_op = ALU_SLL;  ctrl.reg_write = (instr != 32'h0); end
                    FN_JR:   ctrl.jump = JMP_R;
                    FN_JALR: begin
                        ctrl.jump      = JMP_R;
                        ctrl.reg_write = 1'b1;
                        ctrl.wd_sel    = WD_PC8;
                        ctrl.reg_dst   = RD_RD;
                    end
                    FN_MULT:  begin ctrl.md_op = MD_MULT;  uses_md = 1'b1; md_start = 1'b1; end
                    FN_MULTU: begin ctrl.md_op = MD_MULTU; uses_md = 1'b1; md_start = 1'b1; end
                    FN_DIV:   begin ctrl.md_op = MD_DIV;   uses_md = 1'b1; md_start = 1'b1; end
                    FN_DIVU:  begin ctrl.md_op = MD_DIVU;  uses_md = 1'b1; md_start = 1'b1; end
                    FN_MFHI, FN_MFLO: begin
                        ctrl.md_op     = (fn == FN_MFHI) ? MD_MFHI : MD_MFLO;
                        ctrl.hilo_sel  = (fn == FN_MFLO);
                        ctrl.reg_write = 1'b1;
                        ctrl.wd_sel    = WD_HILO;
                        uses_md        = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        ctrl.md_op    = MD_MTHILO;
                        ctrl.hilo_sel = (fn == FN_MTLO);
                        uses_md       = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZ)      ctrl = branch_ctrl(BR_BGEZ);
                else if (rt == RT_BLTZ) ctrl = branch_ctrl(BR_BLTZ);
                else                    illegal = 1'b1;
            end
            OP_ORI:   ctrl = imm_alu_ctrl(ALU_OR,   1'b0);
            OP_ANDI:  ctrl = imm_alu_ctrl(ALU_AND,  1'b0);
            OP_XORI:  ctrl = imm_alu_ctrl(ALU_XOR,  1'b0);
            OP_ADDIU: ctrl = imm_alu_ctrl(ALU_ADDU, 1'b1);
            OP_SLTI:  ctrl = imm_alu_ctrl(ALU_SLT,  1'b1);
            OP_LUI:   ctrl = imm_alu_ctrl(ALU_LUI,  1'b0);
            OP_LW:    ctrl = load_ctrl(MEM_W);
            OP_LH:    ctrl = load_ctrl(MEM_H);
            OP_LHU:   ctrl = load_ctrl(MEM_HU);
            OP_LB:    ctrl = load_ctrl(MEM_B);
            OP_LBU:   ctrl = load_ctrl(MEM_BU);
            OP_SW:    ctrl = store_ctrl(MEM_W);
            OP_SH:    ctrl = store_ctrl(MEM_H);
            OP_SB:    ctrl = store_ctrl(MEM_B);
            OP_BEQ:   ctrl = branch_ctrl(BR_BEQ);
            OP_BNE:   ctrl = branch_ctrl(BR_BNE);
            OP_BGTZ:  ctrl = branch_ctrl(BR_BGTZ);
            OP_BLEZ:  ctrl = branch_ctrl(BR_BLEZ);
            OP_J:     ctrl.jump = JMP_J;
            OP_JAL: begin
                ctrl.jump      = JMP_J;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = RD_RA;
                ctrl.wd_sel    = WD_PC8;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/md_decode_stage.sv
// D-stage decode/control: D/E control register, mult/div busy window and the D-stage stall.
module md_decode_stage
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4,
    parameter int ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr_d,
    input  logic                valid_d,
    input  logic                stall_in,
    input  logic                flush_e,
    output logic                stall_d,
    output logic                md_stall_d,
    output logic                illegal_d,
    output logic                md_busy,
    output logic [ALU_OP_W-1:0] alu_op_e,
    output logic                reg_write_e,
    output logic                mem_write_e,
    output logic                alu_src_e,
    output logic                sign_ext_e,
    output logic [1:0]          reg_dst_e,
    output logic [1:0]          wd_sel_e,
    output logic [2:0]          mem_sel_e,
    output logic [2:0]          branch_e,
    output logic [1:0]          jump_e,
    output logic [2:0]          md_op_e,
    output logic                hilo_sel_e
);

    ctrl_bundle_t     ctrl_p0;
    ctrl_bundle_t     ctrl_p1;
    logic             dec_illegal_p0;
    logic             dec_uses_md_p0;
    logic             dec_md_start_p0;
    logic             is_mult_p0;
    logic             md_issue_p0;
    logic [CNT_W-1:0] md_cnt;

    insn_decoder u_dec (
        .instr    (instr_d),
        .ctrl     (ctrl_p0),
        .illegal  (dec_illegal_p0),
        .uses_md  (dec_uses_md_p0),
        .md_start (dec_md_start_p0)
    );

    // D stage: stall depends only on the counter, never on what already sits in E
    assign md_busy     = (md_cnt != '0);
    assign md_stall_d  = valid_d & dec_uses_md_p0 & md_busy;
    assign stall_d     = stall_in | md_stall_d;
    assign illegal_d   = valid_d & dec_illegal_p0;
    assign is_mult_p0  = (ctrl_p0.md_op == MD_MULT) || (ctrl_p0.md_op == MD_MULTU);
    assign md_issue_p0 = valid_d & dec_md_start_p0 & ~stall_d & ~flush_e;

    // D/E boundary
    always_ff @(posedge clk) begin
        if (reset || flush_e || stall_d || !valid_d) begin
            ctrl_p1 <= '0;
        end else begin
            ctrl_p1 <= ctrl_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_issue_p0) begin
            md_cnt <= is_mult_p0 ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    // E stage outputs
    assign alu_op_e    = ALU_OP_W'(ctrl_p1.alu_op);
    assign reg_write_e = ctrl_p1.reg_write;
    assign mem_write_e = ctrl_p1.mem_write;
    assign alu_src_e   = ctrl_p1.alu_src;
    assign sign_ext_e  = ctrl_p1.sign_ext;
    assign reg_dst_e   = ctrl_p1.reg_dst;
    assign wd_sel_e    = ctrl_p1.wd_sel;
    assign mem_sel_e   = ctrl_p1.mem_sel;
    assign branch_e    = ctrl_p1.branch;
    assign jump_e      = ctrl_p1.jump;
    assign md_op_e     = ctrl_p1.md_op;
    assign hilo_sel_e  = ctrl_p1.hilo_sel;

endmodule

// File: tb/tb_md_decode_stage.sv
// Scoreboard bench for md_decode_stage: mnemonic-level reference model, randomized and directed traffic.
module tb_md_decode_stage;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    typedef enum int {
        K_ADDU, K_SUBU, K_AND, K_OR, K_XOR, K_SLT, K_SLTU, K_SLL, K_SRL, K_SRA,
        K_JR, K_JALR, K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO,
        K_ORI, K_ANDI, K_XORI, K_ADDIU, K_SLTI, K_LUI, K_LW, K_LH, K_LHU, K_LB, K_LBU,
        K_SW, K_SH, K_SB, K_BEQ, K_BNE, K_BGEZ, K_BLTZ, K_BGTZ, K_BLEZ, K_J, K_JAL,
        K_NOP, K_ILL_OP, K_ILL_FN, K_ILL_RI
    } kind_e;

    typedef struct packed {
        logic [3:0] alu;
        logic       rw;
        logic       mw;
        logic       asrc;
        logic       sx;
        logic [1:0] rdst;
        logic [1:0] wd;
        logic [2:0] ms;
        logic [2:0] br;
        logic [1:0] jmp;
        logic [2:0] md;
        logic       hl;
    } eb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_d = 32'h0;
    logic        valid_d = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush_e = 1'b0;
    logic        stall_d, md_stall_d, illegal_d, md_busy;
    logic [3:0]  alu_op_e;
    logic        reg_write_e, mem_write_e, alu_src_e, sign_ext_e, hilo_sel_e;
    logic [1:0]  reg_dst_e, wd_sel_e, jump_e;
    logic [2:0]  mem_sel_e, branch_e, md_op_e;

    md_decode_stage dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
        .stall_in(stall_in), .flush_e(flush_e), .stall_d(stall_d),
        .md_stall_d(md_stall_d), .illegal_d(illegal_d), .md_busy(md_busy),
        .alu_op_e(alu_op_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .alu_src_e(alu_src_e), .sign_ext_e(sign_ext_e), .reg_dst_e(reg_dst_e),
        .wd_sel_e(wd_sel_e), .mem_sel_e(mem_sel_e), .branch_e(branch_e),
        .jump_e(jump_e), .md_op_e(md_op_e), .hilo_sel_e(hilo_sel_e)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  busy_last = -1;
    bit  known = 0;
    eb_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] make_instr(input kind_e k);
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  op, fn;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom_range(1, 31));
        sh = 5'($urandom); imm = 16'($urandom);
        op = 6'h00; fn = 6'h00;
        case (k)
            K_ADDU: fn = 6'h21; K_SUBU: fn = 6'h23; K_AND: fn = 6'h24; K_OR: fn = 6'h25;
            K_XOR: fn = 6'h26; K_SLT: fn = 6'h2A; K_SLTU: fn = 6'h2B; K_SLL: fn = 6'h00;
            K_SRL: fn = 6'h02; K_SRA: fn = 6'h03; K_JR: fn = 6'h08; K_JALR: fn = 6'h09;
            K_MULT: fn = 6'h18; K_MULTU: fn = 6'h19; K_DIV: fn = 6'h1A; K_DIVU: fn = 6'h1B;
            K_MFHI: fn = 6'h10; K_MFLO: fn = 6'h12; K_MTHI: fn = 6'h11; K_MTLO: fn = 6'h13;
            K_ILL_FN: fn = 6'h3F;
            K_ORI: op = 6'h0D; K_ANDI: op = 6'h0C; K_XORI: op = 6'h0E; K_ADDIU: op = 6'h09;
            K_SLTI: op = 6'h0A; K_LUI: op = 6'h0F; K_LW: op = 6'h23; K_LH: op = 6'h21;
            K_LHU: op = 6'h25; K_LB: op = 6'h20; K_LBU: op = 6'h24; K_SW: op = 6'h2B;
            K_SH: op = 6'h29; K_SB: op = 6'h28; K_BEQ: op = 6'h04; K_BNE: op = 6'h05;
            K_BGTZ: op = 6'h07; K_BLEZ: op = 6'h06; K_J: op = 6'h02; K_JAL: op = 6'h03;
            K_ILL_OP: op = 6'h3F;
            K_BGEZ: begin op = 6'h01; rt = 5'h01; end
            K_BLTZ: begin op = 6'h01; rt = 5'h00; end
            K_ILL_RI: begin op = 6'h01; rt = 5'h02; end
            default: ;
        endcase
        if (k == K_NOP) return 32'h0;
        if (op == 6'h00) return {op, rs, rt, rd, sh, fn};
        return {op, rs, rt, imm};
    endfunction

    function automatic eb_t exp_bundle(input kind_e k);
        eb_t e;
        e = '0;
        case (k)
            K_ADDU, K_SUBU, K_AND, K_OR, K_XOR, K_SLT, K_SLTU, K_SLL, K_SRL, K_SRA: begin
                e.rw = 1'b1;
                case (k)
                    K_SUBU: e.alu = 4'd1; K_OR: e.alu = 4'd2; K_SLL: e.alu = 4'd4;
                    K_XOR: e.alu = 4'd5; K_AND: e.alu = 4'd6; K_SLT: e.alu = 4'd7;
                    K_SLTU: e.alu = 4'd8; K_SRL: e.alu = 4'd9; K_SRA: e.alu = 4'd10;
                    default: e.alu = 4'd0;
                endcase
            end
            K_NOP: e.alu = 4'd4;
            K_JR: e.jmp = 2'd2;
            K_JALR: begin e.jmp = 2'd2; e.rw = 1'b1; e.wd = 2'b10; e.rdst = 2'b00; end
            K_MULT: e.md = 3'd1; K_MULTU: e.md = 3'd2; K_DIV: e.md = 3'd3; K_DIVU: e.md = 3'd4;
            K_MFHI: begin e.md = 3'd5; e.rw = 1'b1; e.wd = 2'b11; e.hl = 1'b0; end
            K_MFLO: begin e.md = 3'd6; e.rw = 1'b1; e.wd = 2'b11; e.hl = 1'b1; end
            K_MTHI: e.md = 3'd7;
            K_MTLO: begin e.md = 3'd7; e.hl = 1'b1; end
            K_ORI, K_ANDI, K_XORI, K_ADDIU, K_SLTI, K_LUI: begin
                e.rw = 1'b1; e.asrc = 1'b1; e.rdst = 2'b01;
                e.sx = (k == K_ADDIU || k == K_SLTI);
                case (k)
                    K_ORI: e.alu = 4'd2; K_ANDI: e.alu = 4'd6; K_XORI: e.alu = 4'd5;
                    K_SLTI: e.alu = 4'd7; K_LUI: e.alu = 4'd3; default: e.alu = 4'd0;
                endcase
            end
            K_LW, K_LH, K_LHU, K_LB, K_LBU: begin
                e.rw = 1'b1; e.asrc = 1'b1; e.sx = 1'b1; e.rdst = 2'b01; e.wd = 2'b01;
                case (k)
                    K_LH: e.ms = 3'b010; K_LHU: e.ms = 3'b110; K_LB: e.ms = 3'b001;
                    K_LBU: e.ms = 3'b101; default: e.ms = 3'b000;
                endcase
            end
            K_SW, K_SH, K_SB: begin
                e.mw = 1'b1; e.asrc = 1'b1; e.sx = 1'b1;
                e.ms = (k == K_SH) ? 3'b010 : (k == K_SB) ? 3'b001 : 3'b000;
            end
            K_BEQ: begin e.sx = 1'b1; e.br = 3'd1; end
            K_BNE: begin e.sx = 1'b1; e.br = 3'd2; end
            K_BGEZ: begin e.sx = 1'b1; e.br = 3'd3; end
            K_BGTZ: begin e.sx = 1'b1; e.br = 3'd4; end
            K_BLEZ: begin e.sx = 1'b1; e.br = 3'd5; end
            K_BLTZ: begin e.sx = 1'b1; e.br = 3'd6; end
            K_J: e.jmp = 2'd1;
            K_JAL: begin e.jmp = 2'd1; e.rw = 1'b1; e.rdst = 2'b10; e.wd = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit is_md(input kind_e k);
        return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO};
    endfunction

    function automatic bit is_start(input kind_e k);
        return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU};
    endfunction

    task automatic step(input bit rst_i, input bit vld_i, input kind_e k, input logic [31:0] ins,
                        input bit stl_i, input bit fl_i, output bit stalled);
        bit  busy_m, mdst_m, st_m, ill_m;
        eb_t eb;
        @(negedge clk);
        reset = rst_i; valid_d = vld_i; instr_d = ins; stall_in = stl_i; flush_e = fl_i;
        #1;
        busy_m = (cyc <= busy_last);
        mdst_m = vld_i && is_md(k) && busy_m;
        st_m   = stl_i || mdst_m;
        ill_m  = vld_i && (k inside {K_ILL_OP, K_ILL_FN, K_ILL_RI});
        if (known) begin
            chk("md_busy", 32'(md_busy), 32'(busy_m));
            chk("md_stall_d", 32'(md_stall_d), 32'(mdst_m));
            chk("stall_d", 32'(stall_d), 32'(st_m));
            chk("illegal_d", 32'(illegal_d), 32'(ill_m));
        end
        eb = (rst_i || fl_i || st_m || !vld_i) ? eb_t'('0) : exp_bundle(k);
        exp_q.push_back(eb);
        if (rst_i) busy_last = cyc;
        else if (vld_i && is_start(k) && !st_m && !fl_i)
            busy_last = cyc + ((k == K_MULT || k == K_MULTU) ? N_MULT : N_DIV);
        stalled = st_m;
        cyc++;
        if (rst_i) known = 1;
    endtask

    // Presents k without external stalls until it is accepted; returns how many cycles it was held.
    task automatic issue(input kind_e k, output int n_stall);
        logic [31:0] ins;
        bit st;
        ins = make_instr(k);
        n_stall = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, k, ins, 1'b0, 1'b0, st);
            if (!st) return;
            n_stall++;
        end
        chk("issue_timeout", 32'(n_stall), 32'd0);
    endtask

    // Monitor: every edge presents a new E bundle; compare it with the oldest expectation.
    initial begin
        eb_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {alu_op_e, reg_write_e, mem_write_e, alu_src_e, sign_ext_e, reg_dst_e,
                     wd_sel_e, mem_sel_e, branch_e, jump_e, md_op_e, hilo_sel_e};
                chk("e_bundle", 32'(a), 32'(e));
            end
        end
    end

    initial begin
        bit st;
        int ns;
        kind_e       rk;
        logic [31:0] rins;
        bit          hold;

        step(1'b1, 1'b1, K_DIV, make_instr(K_DIV), 1'b0, 1'b0, st);
        step(1'b1, 1'b1, K_DIV, make_instr(K_DIV), 1'b0, 1'b0, st);
        step(1'b0, 1'b0, K_NOP, 32'h0, 1'b0, 1'b0, st);

        for (int k = 0; k <= int'(K_ILL_RI); k++) issue(kind_e'(k), ns);

        issue(K_NOP, ns);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, K_NOP, 32'h0, 1'b0, 1'b0, st);
        issue(K_DIV, ns);
        issue(K_MFLO, ns);
        chk("div_mflo_stalls", 32'(ns), 32'(N_DIV));

        issue(K_MULT, ns);
        for (int i = 0; i < 3; i++) issue(K_ADDU, ns);
        issue(K_MFHI, ns);
        chk("mult_mfhi_stalls", 32'(ns), 32'(N_MULT - 3));

        step(1'b0, 1'b1, K_MULT, make_instr(K_MULT), 1'b0, 1'b1, st);
        issue(K_MFHI, ns);
        chk("flushed_mult_stalls", 32'(ns), 32'd0);

        rins = make_instr(K_ADDU);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, K_ADDU, rins, 1'b1, 1'b0, st);
        step(1'b0, 1'b1, K_ADDU, rins, 1'b0, 1'b0, st);

        issue(K_MULT, ns);
        step(1'b0, 1'b1, K_NOP, 32'h0, 1'b0, 1'b0, st);
        step(1'b1, 1'b1, K_ADDU, make_instr(K_ADDU), 1'b0, 1'b0, st);
        issue(K_MFHI, ns);
        chk("reset_mid_window_stalls", 32'(ns), 32'd0);

        issue(K_ILL_OP, ns);

        hold = 0;
        rk = K_NOP;
        rins = 32'h0;
        for (int i = 0; i < 800; i++) begin
            if (!hold) begin
                rk   = kind_e'($urandom_range(0, int'(K_ILL_RI)));
                rins = make_instr(rk);
            end
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), rk, rins,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), st);
            hold = st;
        end

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/md_decode_stage.md
Name: md_decode_stage

Overview:
- Next-generation decode/control block for the 5-stage MIPS pipeline, replacing the purely combinational instruction decoder.
- Decodes the extended instruction set (including mult/div and HI/LO moves) from the D-stage instruction and registers the resulting control bundle into the D/E pipeline register.
- Tracks the multi-cycle multiply/divide busy window with an internal counter and raises a D-stage stall for HI/LO-using instructions while that window is open.

Parameters:
MULT_CYCLES, 5, E-stage busy cycles for mult/multu
DIV_CYCLES, 10, E-stage busy cycles for div/divu
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
ALU_OP_W, 4, width of the ALU operation code

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instr_d  in  32  instruction in the D stage
valid_d  in  1  D-stage slot holds a real instruction
stall_in  in  1  external hazard-unit stall (data hazards)
flush_e  in  1  insert a bubble into E regardless of stall state
stall_d  out  1  freeze PC and F/D register: stall_in | md_stall_d
md_stall_d  out  1  stall caused by the mult/div busy window
illegal_d  out  1  comb: valid_d and opcode/funct not recognised
md_busy  out  1  md_cnt != 0
alu_op_e  out  ALU_OP_W  ALU op: 0 addu,1 subu,2 or,3 lui,4 sll,5 xor,6 and,7 slt,8 sltu,9 srl,10 sra
reg_write_e  out  1  GRF write enable
mem_write_e  out  1  DM write enable
alu_src_e  out  1  1 selects the extended immediate
sign_ext_e  out  1  1 sign-extends, 0 zero-extends the immediate
reg_dst_e  out  2  00 rd, 01 rt, 10 $31
wd_sel_e  out  2  00 ALU, 01 memory, 10 PC+8, 11 HI/LO
mem_sel_e  out  3  bit[1:0]: 00 word, 01 byte, 10 half; bit2: unsigned load
branch_e  out  3  0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz
jump_e  out  2  0 none, 1 j/jal, 2 jr/jalr
md_op_e  out  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi/mtlo (hilo_sel_e picks)
hilo_sel_e  out  1  0 HI, 1 LO

Behaviour:
- Decode set:
  - R-type: addu subu and or xor slt sltu sll srl sra jr jalr mult multu div divu mfhi mflo mthi mtlo.
  - I-type: ori andi xori addiu slti lui lw lh lhu lb lbu sw sh sb beq bne.
  - REGIMM (op 000001, rt 00001 = bgez, rt 00000 = bltz): bgez bltz.
  - Others: bgtz blez j jal.
  - All-zero word decodes as sll $0 (nop); it produces no side effects.
- Unrecognised instruction: all enables 0, alu_op 0, illegal_d = 1; it flows through as a bubble.
- sign_ext is 1 for addiu, slti, all loads, all stores and all branches; 0 for ori, andi, xori.
- uses_md_d = valid_d & (mult, multu, div, divu, mfhi, mflo, mthi, mtlo). md_start_d = the first four only.
- md_stall_d = uses_md_d & md_busy (comb, no dependence on E contents).
- E register update at posedge clk, in priority order:
  1. reset: all *_e outputs 0 (bubble).
  2. flush_e: bubble.
  3. stall_d: bubble.
  4. otherwise load the decoded bundle, gated with valid_d (valid_d = 0 loads a bubble).
- md_cnt update at posedge clk, in priority order:
  1. reset: 0.
  2. md_start_d & valid_d & ~stall_d & ~flush_e: load MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
  3. md_cnt != 0: decrement by 1.
  4. otherwise hold.
- Busy window timing: md_busy rises the cycle the start instruction sits in E and stays high for exactly N cycles.
- An md instruction in D stalls while md_cnt >= 1 and issues on the cycle md_cnt == 0 (the cycle after md_cnt reaches 1 is the first non-busy cycle).
- Flushed starts do not load the counter. Reset mid-window clears the counter immediately with no residual stall.
- Counter keeps decrementing during stall_in or flush_e cycles.
- mthi/mtlo/mfhi/mflo never load the counter.
- No combinational path from *_e outputs back to stall_d.

Decomposition:
- Shared package md_ctrl_pkg holds:
  - opcode and funct localparams;
  - ALU_OP, WD_SEL, REG_DST, BRANCH and MD_OP encodings;
  - a ctrl_bundle struct for the E-stage fields.
- One sub-module, insn_decoder: pure combinational instr -> ctrl_bundle, illegal, uses_md, md_start.
- The top level holds the D/E register, md_cnt and the stall logic.

Test Plan:
- Reset: reset = 1 for 2 cycles with valid div in D -> all *_e = 0, md_cnt = 0, stall_d = 0 after release.
- Decode sweep: one instruction of each class, no stalls -> next-cycle bundle matches; e.g. lhu gives wd_sel_e = 01, mem_sel_e = 110, reg_dst_e = 01, sign_ext_e = 1; jalr gives jump_e = 2, wd_sel_e = 10, reg_dst_e = 00.
- Divide window: div then mflo back-to-back with DIV_CYCLES = 10 -> md_stall_d high for 10 cycles, 10 bubbles inserted, mflo enters E with md_op_e = 6 on the 11th cycle.
- Interleaved ALU work: mult, then addu ×3, then mfhi -> addu ops flow unstalled; mfhi stalls 2 cycles (5 − 3).
- Flush and external stall: flush_e with mult in D -> md_cnt stays 0. stall_in held 3 cycles with addu in D -> 3 bubbles, then addu loads, md_cnt unaffected.
- Boundary conditions: reset asserted at md_cnt = 4 -> md_cnt = 0 next cycle, mfhi in D issues immediately. Illegal opcode 0x3F -> illegal_d = 1, all enables 0 in E.
